// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: single-port word array with AMO support, a one-deep
// stage register and an in-order response FIFO with credit-based request flow control.
module tcdm_bank_responder #(
    parameter int unsigned NumWords      = 1024,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned MetaWidth     = 19,
    parameter int unsigned RespFifoDepth = 4,
    localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth      = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [3:0]           req_amo_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    input  logic [MetaWidth-1:0] req_meta_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DataWidth-1:0] resp_rdata_o,
    output logic [MetaWidth-1:0] resp_meta_o
);

    localparam int unsigned PtrWidth = $clog2(RespFifoDepth);
    localparam int unsigned CntWidth = $clog2(RespFifoDepth + 1);
    localparam int unsigned OutWidth = CntWidth + 1;

    if (RespFifoDepth < 2 || RespFifoDepth > 16) begin : g_bad_depth
        $error("RespFifoDepth must be within 2..16");
    end
    if (DataWidth == 0 || (DataWidth % 8) != 0) begin : g_bad_width
        $error("DataWidth must be a non-zero multiple of 8");
    end
    if (NumWords < 1) begin : g_bad_words
        $error("NumWords must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StAmoWb} state_e;

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic                  stage_valid_q;
    logic [DataWidth-1:0]  stage_rdata_q, stage_wdata_q;
    logic [MetaWidth-1:0]  stage_meta_q;
    logic [AddrWidth-1:0]  stage_addr_q;
    logic [3:0]            stage_amo_q;

    logic [DataWidth-1:0]  mem_q [NumWords];
    logic [DataWidth-1:0]  fifo_rdata_q [RespFifoDepth];
    logic [MetaWidth-1:0]  fifo_meta_q [RespFifoDepth];

    logic                  accept, req_is_amo, push, pop;
    logic                  mem_we;
    logic [AddrWidth-1:0]  mem_waddr;
    logic [DataWidth-1:0]  mem_wdata, amo_result;
    logic [BeWidth-1:0]    mem_wbe;
    logic [OutWidth-1:0]   outstanding, outstanding_d;

    assign accept      = req_valid_i && req_ready_o;
    assign req_is_amo  = (req_amo_i != 4'd0) && (req_amo_i <= 4'd9);
    assign push        = stage_valid_q;
    assign pop         = resp_valid_o && resp_ready_i;
    assign req_ready_o = ready_q;

    assign resp_valid_o = (count_q != '0);
    assign resp_rdata_o = fifo_rdata_q[rd_ptr_q];
    assign resp_meta_o  = fifo_meta_q[rd_ptr_q];

    assign outstanding = OutWidth'(count_q) + OutWidth'(stage_valid_q);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespFifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_comb begin
        amo_result = stage_rdata_q;
        case (stage_amo_q)
            4'd1: amo_result = stage_wdata_q;
            4'd2: amo_result = stage_rdata_q + stage_wdata_q;
            4'd3: amo_result = stage_rdata_q & stage_wdata_q;
            4'd4: amo_result = stage_rdata_q | stage_wdata_q;
            4'd5: amo_result = stage_rdata_q ^ stage_wdata_q;
            4'd6: amo_result = ($signed(stage_rdata_q) > $signed(stage_wdata_q)) ?
                               stage_rdata_q : stage_wdata_q;
            4'd7: amo_result = (stage_rdata_q > stage_wdata_q) ? stage_rdata_q : stage_wdata_q;
            4'd8: amo_result = ($signed(stage_rdata_q) < $signed(stage_wdata_q)) ?
                               stage_rdata_q : stage_wdata_q;
            4'd9: amo_result = (stage_rdata_q < stage_wdata_q) ? stage_rdata_q : stage_wdata_q;
            default: ;
        endcase
    end

    // The single array port is shared: AMO write-back owns it in StAmoWb, where no accept occurs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr_i;
        mem_wdata = req_wdata_i;
        mem_wbe   = req_be_i;
        if (state_q == StAmoWb) begin
            mem_we    = 1'b1;
            mem_waddr = stage_addr_q;
            mem_wdata = amo_result;
            mem_wbe   = '1;
        end else if (accept && req_write_i && (req_amo_i == 4'd0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BeWidth; b++) begin
                if (mem_wbe[b]) mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata_q[wr_ptr_q] <= stage_rdata_q;
            fifo_meta_q[wr_ptr_q]  <= stage_meta_q;
        end
    end

    always_comb begin
        count_d       = count_q + CntWidth'(push) - CntWidth'(pop);
        state_d       = (state_q == StIdle && accept && req_is_amo) ? StAmoWb : StIdle;
        outstanding_d = OutWidth'(count_d) + OutWidth'(accept);
        ready_d       = (outstanding_d < OutWidth'(RespFifoDepth)) && (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ready_q       <= 1'b1;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stage_valid_q <= 1'b0;
            stage_rdata_q <= '0;
            stage_wdata_q <= '0;
            stage_meta_q  <= '0;
            stage_addr_q  <= '0;
            stage_amo_q   <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            count_q       <= count_d;
            stage_valid_q <= accept;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (accept) begin
                stage_rdata_q <= mem_q[req_addr_i];
                stage_wdata_q <= req_wdata_i;
                stage_meta_q  <= req_meta_i;
                stage_addr_q  <= req_addr_i;
                stage_amo_q   <= req_is_amo ? req_amo_i : 4'd0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !pop) |-> (count_q < CntWidth'(RespFifoDepth)));
    a_stable_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (resp_valid_o && !resp_ready_i) |=> ($stable(resp_rdata_o) && $stable(resp_meta_o)));
    a_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding <= OutWidth'(RespFifoDepth));

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench for tcdm_bank_responder: a word-array reference model predicts every
// response at acceptance; a negedge monitor checks responses in order.
module tb_tcdm_bank_responder;

    localparam int AW = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [3:0]  req_amo_i, req_be_i;
    logic [31:0] req_wdata_i, resp_rdata_o;
    logic [18:0] req_meta_i, resp_meta_o;
    logic        resp_valid_o, resp_ready_i;

    tcdm_bank_responder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_amo_i    (req_amo_i),
        .req_write_i  (req_write_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .req_meta_i   (req_meta_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_meta_o  (resp_meta_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          chk;
        logic [31:0] rdata;
        logic [18:0] meta;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [1024];
    bit          ref_known [1024];
    int          vectors = 0;
    int          miscompares = 0;
    int          rr_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] amo_apply(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'd1: return b;
            4'd2: return a + b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return ($signed(a) > $signed(b)) ? a : b;
            4'd7: return (a > b) ? a : b;
            4'd8: return ($signed(a) < $signed(b)) ? a : b;
            4'd9: return (a < b) ? a : b;
            default: return a;
        endcase
    endfunction

    // Reference: the response carries the word as it was; the word then takes its new value.
    task automatic model(input logic [AW-1:0] a, input logic [3:0] op, input logic w,
                         input logic [31:0] d, input logic [3:0] be, input logic [18:0] m);
        exp_t e;
        e.chk   = ref_known[a];
        e.rdata = ref_mem[a];
        e.meta  = m;
        exp_q.push_back(e);
        if (op >= 4'd1 && op <= 4'd9) begin
            ref_mem[a] = amo_apply(op, ref_mem[a], d);
            if (op == 4'd1) ref_known[a] = 1'b1;
        end else if (op == 4'd0 && w) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            if (be == 4'hF) ref_known[a] = 1'b1;
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [3:0] op, input logic w,
                        input logic [31:0] d, input logic [3:0] be, input logic [18:0] m);
        int n = 0;
        @(negedge clk_i);
        req_addr_i = a; req_amo_i = op; req_write_i = w;
        req_wdata_i = d; req_be_i = be; req_meta_i = m;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: req_ready_o stayed %b, expected 1", req_ready_o);
            req_valid_i = 1'b0;
        end else begin
            model(a, op, w, d, be, m);
            @(posedge clk_i);
            #1 req_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (rr_mode)
                0:       resp_ready_i = 1'b0;
                1:       resp_ready_i = 1'b1;
                default: resp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_o && resp_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: meta %h with empty scoreboard", resp_meta_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_meta_o !== mon_e.meta || (mon_e.chk && resp_rdata_o !== mon_e.rdata)) begin
                    miscompares++;
                    $display("FAIL resp: got rdata %h meta %h, expected rdata %h meta %h (chk %0d)",
                             resp_rdata_o, resp_meta_o, mon_e.rdata, mon_e.meta, mon_e.chk);
                end
            end
        end
    end

    initial begin
        int n_acc;
        logic [3:0] op;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_amo_i = '0;
        req_write_i = 1'b0; req_wdata_i = '0; req_be_i = '0; req_meta_i = '0;
        resp_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_resp_valid", 32'(resp_valid_o), 32'd0);
        check("reset_req_ready", 32'(req_ready_o), 32'd1);
        rst_ni = 1'b1;

        // Read-before-write and two-cycle latency.
        send(5, 0, 1, 32'h01020304, 4'hF, 19'h01);
        drain(50);
        send(5, 0, 1, 32'hDEADBEEF, 4'hF, 19'h12);
        @(negedge clk_i);
        check("latency_t1", 32'(resp_valid_o), 32'd0);
        @(negedge clk_i);
        check("latency_t2", 32'(resp_valid_o), 32'd1);
        send(5, 0, 0, 32'h0, 4'hF, 19'h34);
        drain(50);

        // Byte-lane write.
        send(7, 0, 1, 32'h11223344, 4'hF, 19'h02);
        send(7, 0, 1, 32'hAABBCCDD, 4'b0101, 19'h03);
        send(7, 0, 0, 32'h0, 4'hF, 19'h04);
        drain(50);

        // AMOs followed immediately by reads.
        send(9, 0, 1, 32'h7FFFFFFF, 4'hF, 19'h05);
        send(9, 2, 0, 32'h1, 4'h0, 19'h06);
        check("amo_ready_low", 32'(req_ready_o), 32'd0);
        send(9, 0, 0, 32'h0, 4'hF, 19'h07);
        send(9, 0, 1, 32'h7FFFFFFF, 4'hF, 19'h08);
        send(9, 6, 0, 32'hFFFFFFFF, 4'h0, 19'h09);
        send(9, 0, 0, 32'h0, 4'hF, 19'h0A);
        send(9, 7, 0, 32'hFFFFFFFF, 4'h0, 19'h0B);
        send(9, 0, 0, 32'h0, 4'hF, 19'h0C);
        send(9, 4'd12, 1, 32'h0, 4'hF, 19'h0D);
        send(9, 0, 0, 32'h0, 4'hF, 19'h0E);
        drain(50);

        // Back-pressure: only RespFifoDepth requests get in.
        rr_mode = 0;
        repeat (2) @(posedge clk_i);
        n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (n_acc < 10) begin
                req_addr_i = 5; req_amo_i = 0; req_write_i = 0; req_wdata_i = '0;
                req_be_i = 4'hF; req_meta_i = 19'(32'h100 + n_acc); req_valid_i = 1'b1;
                if (req_ready_o) begin
                    model(5, 0, 0, 32'h0, 4'hF, 19'(32'h100 + n_acc));
                    n_acc++;
                end
            end
        end
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        check("stall_accepted", 32'(n_acc), 32'd4);
        check("stall_ready_low", 32'(req_ready_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("stall_valid", 32'(resp_valid_o), 32'd1);
            check("stall_meta", 32'(resp_meta_o), 32'h100);
            check("stall_rdata", resp_rdata_o, 32'hDEADBEEF);
        end
        rr_mode = 1;
        for (int i = 4; i < 10; i++) send(5, 0, 0, 32'h0, 4'hF, 19'(32'h100 + i));
        drain(100);

        // Reset with buffered responses.
        rr_mode = 0;
        repeat (2) @(posedge clk_i);
        for (int i = 0; i < 3; i++) send(7, 0, 0, 32'h0, 4'hF, 19'(32'h20 + i));
        repeat (4) @(negedge clk_i);
        check("rst_pre_valid", 32'(resp_valid_o), 32'd1);
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        rr_mode = 1;
        repeat (8) @(negedge clk_i);
        check("rst_no_stale", 32'(resp_valid_o), 32'd0);
        send(7, 0, 0, 32'h0, 4'hF, 19'h2F);
        drain(50);

        // Randomised traffic over a small, fully initialised address window.
        for (int a = 0; a < 16; a++) send(AW'(a), 0, 1, $urandom, 4'hF, 19'(32'h300 + a));
        drain(100);
        rr_mode = 2;
        for (int i = 0; i < 2000; i++) begin
            op = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            send(AW'($urandom_range(0, 15)), op, 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)), 19'($urandom));
        end
        rr_mode = 1;
        drain(5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
